// File: rtl/cache_controller_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cache_controller_nway                                          |
// | Brief    : N-way set-associative L1D controller FSM with true-LRU ages,   |
// |            dirty write-back, optional write-allocate and L2 sequencing.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cache_controller_nway #(
   parameter int ADDR_W         = 32,
   parameter int TAG_W          = 21,
   parameter int WAYS           = 4,
   parameter int BURST          = 8,
   parameter int L2_WR_CYC      = 8,
   parameter int WRITE_ALLOCATE = 0,
   localparam int AGE_W         = $clog2(WAYS)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_ld,
   input  logic                    i_st,
   input  logic [ADDR_W-1:0]       i_addr,
   input  logic [WAYS*TAG_W-1:0]   i_tag_loaded,
   input  logic [WAYS-1:0]         i_valid,
   input  logic [WAYS-1:0]         i_dirty,
   input  logic [WAYS*AGE_W-1:0]   i_age,
   input  logic                    i_l2_ack,
   output logic                    o_hit,
   output logic                    o_miss,
   output logic [AGE_W-1:0]        o_way_sel,
   output logic [TAG_W-1:0]        o_tag_out,
   output logic [WAYS-1:0]         o_tag_en,
   output logic [WAYS-1:0]         o_valid_en,
   output logic [WAYS-1:0]         o_dirty_en,
   output logic                    o_dirty_val,
   output logic                    o_load_ready,
   output logic [WAYS-1:0]         o_write_l1,
   output logic                    o_read_l2,
   output logic                    o_write_l2,
   output logic [WAYS*AGE_W-1:0]   o_age_new,
   output logic                    o_age_en,
   output logic [3:0]              o_state,
   output logic [3:0]              o_count,
   output logic                    o_busy
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_READ_L1    = 4'd1,
      S_WRITE_L1   = 4'd2,
      S_WRITE_L2   = 4'd3,
      S_WRITE_BACK = 4'd4,
      S_ALLOCATE   = 4'd5,
      S_UPDATE_L1  = 4'd6
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_count;
   logic [AGE_W-1:0]        r_way;
   logic [TAG_W-1:0]        r_tag;
   logic                    r_op_ld;
   logic                    r_hit, r_miss, r_dirty_val, r_load_ready;
   logic                    r_read_l2, r_write_l2, r_age_en, r_busy;
   logic [WAYS-1:0]         r_tag_en, r_valid_en, r_dirty_en, r_write_l1;
   logic [WAYS*AGE_W-1:0]   r_age_new;

   logic [TAG_W-1:0]        w_req_tag;
   logic                    w_accept;
   logic                    w_hit;
   logic [AGE_W-1:0]        w_hit_way;
   logic                    w_have_inv;
   logic [AGE_W-1:0]        w_victim;
   logic                    w_victim_dirty;
   state_t                  w_nstate;
   logic [3:0]              w_ncount;
   logic [AGE_W-1:0]        w_nway;
   logic [WAYS-1:0]         w_way_oh;
   logic [AGE_W-1:0]        w_acc_age;
   logic [WAYS*AGE_W-1:0]   w_age_upd;
   logic                    w_unused_addr;

   assign w_req_tag      = i_addr[ADDR_W-1 -: TAG_W];
   assign w_unused_addr  = ^i_addr[ADDR_W-TAG_W-1:0];
   assign w_accept       = (r_state == S_IDLE) && (i_ld || i_st);
   assign w_victim_dirty = i_valid[w_victim] && i_dirty[w_victim];
   assign w_nway         = w_accept ? (w_hit ? w_hit_way : w_victim) : r_way;
   assign w_way_oh       = WAYS'(1) << w_nway;
   assign w_acc_age      = i_age[int'(w_nway)*AGE_W +: AGE_W];

   // Tag compare and victim choice; descending scans leave the lowest index.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_way  = '0;
      w_have_inv = 1'b0;
      w_victim   = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (i_valid[w] && (i_tag_loaded[w*TAG_W +: TAG_W] == w_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = AGE_W'(w);
         end
      end
      for (int w = WAYS-1; w >= 0; w--) begin
         if (!i_valid[w]) begin
            w_have_inv = 1'b1;
            w_victim   = AGE_W'(w);
         end
      end
      if (!w_have_inv) begin
         for (int w = WAYS-1; w >= 0; w--) begin
            if (i_age[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1)) begin
               w_victim = AGE_W'(w);
            end
         end
      end
   end

   // True-LRU update for the accessed way: it becomes MRU, younger ways age by one.
   always_comb begin
      w_age_upd = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == w_nway) begin
            w_age_upd[w*AGE_W +: AGE_W] = '0;
         end else if (i_age[w*AGE_W +: AGE_W] < w_acc_age) begin
            w_age_upd[w*AGE_W +: AGE_W] = i_age[w*AGE_W +: AGE_W] + AGE_W'(1);
         end else begin
            w_age_upd[w*AGE_W +: AGE_W] = i_age[w*AGE_W +: AGE_W];
         end
      end
   end

   // Next state and burst counter; the counter restarts from 0 on every entry.
   always_comb begin
      w_nstate = S_IDLE;
      w_ncount = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_hit) begin
                  w_nstate = i_ld ? S_READ_L1 : S_WRITE_L1;
               end else if (i_ld || (WRITE_ALLOCATE != 0)) begin
                  w_nstate = w_victim_dirty ? S_WRITE_BACK : S_ALLOCATE;
               end else begin
                  w_nstate = S_WRITE_L2;
               end
            end
         end
         S_READ_L1, S_WRITE_L1: w_nstate = S_IDLE;
         S_WRITE_L2: begin
            if (r_count != 4'(L2_WR_CYC-1)) begin
               w_nstate = S_WRITE_L2;
               w_ncount = r_count + 4'd1;
            end
         end
         S_WRITE_BACK: begin
            if (r_count == 4'(BURST-1)) begin
               w_nstate = S_ALLOCATE;
            end else begin
               w_nstate = S_WRITE_BACK;
               w_ncount = r_count + 4'd1;
            end
         end
         S_ALLOCATE:  w_nstate = i_l2_ack ? S_UPDATE_L1 : S_ALLOCATE;
         S_UPDATE_L1: w_nstate = r_op_ld ? S_READ_L1 : S_WRITE_L1;
         default:     w_nstate = S_IDLE;
      endcase
   end

   // FSM register: every output is registered from the state being entered.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_count      <= 4'd0;
         r_way        <= '0;
         r_tag        <= '0;
         r_op_ld      <= 1'b0;
         r_hit        <= 1'b0;
         r_miss       <= 1'b0;
         r_dirty_val  <= 1'b0;
         r_load_ready <= 1'b0;
         r_read_l2    <= 1'b0;
         r_write_l2   <= 1'b0;
         r_age_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_tag_en     <= '0;
         r_valid_en   <= '0;
         r_dirty_en   <= '0;
         r_write_l1   <= '0;
         r_age_new    <= '0;
      end else begin
         r_state      <= w_nstate;
         r_count      <= w_ncount;
         r_way        <= w_nway;
         r_tag        <= w_accept ? w_req_tag : r_tag;
         r_op_ld      <= w_accept ? i_ld : r_op_ld;
         r_hit        <= w_accept && w_hit;
         r_miss       <= w_accept && !w_hit;
         r_load_ready <= (w_nstate == S_READ_L1);
         r_age_en     <= (w_nstate == S_READ_L1) || (w_nstate == S_WRITE_L1);
         r_age_new    <= ((w_nstate == S_READ_L1) || (w_nstate == S_WRITE_L1)) ? w_age_upd : '0;
         r_write_l1   <= ((w_nstate == S_WRITE_L1) || (w_nstate == S_UPDATE_L1)) ? w_way_oh : '0;
         r_dirty_en   <= ((w_nstate == S_WRITE_L1) || (w_nstate == S_UPDATE_L1) ||
                          ((w_nstate == S_WRITE_BACK) && (w_ncount == 4'(BURST-1)))) ? w_way_oh : '0;
         r_dirty_val  <= (w_nstate == S_WRITE_L1);
         r_tag_en     <= (w_nstate == S_UPDATE_L1) ? w_way_oh : '0;
         r_valid_en   <= (w_nstate == S_UPDATE_L1) ? w_way_oh : '0;
         r_read_l2    <= (w_nstate == S_ALLOCATE);
         r_write_l2   <= (w_nstate == S_WRITE_L2) || (w_nstate == S_WRITE_BACK);
         r_busy       <= (w_nstate != S_IDLE);
      end
   end

   assign o_hit        = r_hit;
   assign o_miss       = r_miss;
   assign o_way_sel    = r_way;
   assign o_tag_out    = r_tag;
   assign o_tag_en     = r_tag_en;
   assign o_valid_en   = r_valid_en;
   assign o_dirty_en   = r_dirty_en;
   assign o_dirty_val  = r_dirty_val;
   assign o_load_ready = r_load_ready;
   assign o_write_l1   = r_write_l1;
   assign o_read_l2    = r_read_l2;
   assign o_write_l2   = r_write_l2;
   assign o_age_new    = r_age_new;
   assign o_age_en     = r_age_en;
   assign o_state      = r_state;
   assign o_count      = r_count;
   assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cache_controller_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cache_controller_nway                                       |
// | Brief    : Bench for cache_controller_nway: hit-vector table, hand-made   |
// |            cold-miss and mid-burst-reset sequences, random transactions   |
// |            against a recency-list reference model (WA = 0 and WA = 1).    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cache_controller_nway;

   typedef struct packed {
      logic [3:0]  st;
      logic        hit;
      logic        miss;
      logic [1:0]  way;
      logic        wl2;
      logic        rl2;
      logic        ldr;
      logic        age_en;
      logic [3:0]  cnt;
      logic [3:0]  tag_en;
      logic [3:0]  valid_en;
      logic [3:0]  dirty_en;
      logic        dval;
      logic [3:0]  wl1;
      logic [7:0]  age_new;
      logic        busy;
      logic [20:0] tag_out;
   } exp_t;

   typedef struct {
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [83:0] tags;
      logic [3:0]  valid;
      logic [7:0]  ages;
      logic [3:0]  exp_state;
      logic [1:0]  exp_way;
      logic [7:0]  exp_age;
   } vec_t;

   localparam logic [20:0] T  = 21'h1FFFFF;
   localparam logic [20:0] Z  = 21'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ld_v, st_v;
   logic        ack;
   logic [31:0] addr;
   logic [83:0] tags;
   logic [3:0]  vl, dt;
   logic [7:0]  ages;

   logic        hit_w [2], miss_w [2], dval_w [2], ldr_w [2], rl2_w [2], wl2_w [2], age_en_w [2], busy_w [2];
   logic [1:0]  way_w [2];
   logic [20:0] tag_out_w [2];
   logic [3:0]  tag_en_w [2], valid_en_w [2], dirty_en_w [2], wl1_w [2], state_w [2], count_w [2];
   logic [7:0]  age_new_w [2];

   int   n_pass = 0;
   int   n_total = 0;
   exp_t q_exp[$];
   vec_t tv[8];

   always #5 clk = ~clk;

   cache_controller_nway #(.WRITE_ALLOCATE(0)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_ld(ld_v[0]), .i_st(st_v[0]), .i_addr(addr),
      .i_tag_loaded(tags), .i_valid(vl), .i_dirty(dt), .i_age(ages), .i_l2_ack(ack),
      .o_hit(hit_w[0]), .o_miss(miss_w[0]), .o_way_sel(way_w[0]), .o_tag_out(tag_out_w[0]),
      .o_tag_en(tag_en_w[0]), .o_valid_en(valid_en_w[0]), .o_dirty_en(dirty_en_w[0]),
      .o_dirty_val(dval_w[0]), .o_load_ready(ldr_w[0]), .o_write_l1(wl1_w[0]),
      .o_read_l2(rl2_w[0]), .o_write_l2(wl2_w[0]), .o_age_new(age_new_w[0]),
      .o_age_en(age_en_w[0]), .o_state(state_w[0]), .o_count(count_w[0]), .o_busy(busy_w[0])
   );

   cache_controller_nway #(.WRITE_ALLOCATE(1)) u_dut_wa (
      .i_clk(clk), .i_reset(rst), .i_ld(ld_v[1]), .i_st(st_v[1]), .i_addr(addr),
      .i_tag_loaded(tags), .i_valid(vl), .i_dirty(dt), .i_age(ages), .i_l2_ack(ack),
      .o_hit(hit_w[1]), .o_miss(miss_w[1]), .o_way_sel(way_w[1]), .o_tag_out(tag_out_w[1]),
      .o_tag_en(tag_en_w[1]), .o_valid_en(valid_en_w[1]), .o_dirty_en(dirty_en_w[1]),
      .o_dirty_val(dval_w[1]), .o_load_ready(ldr_w[1]), .o_write_l1(wl1_w[1]),
      .o_read_l2(rl2_w[1]), .o_write_l2(wl2_w[1]), .o_age_new(age_new_w[1]),
      .o_age_en(age_en_w[1]), .o_state(state_w[1]), .o_count(count_w[1]), .o_busy(busy_w[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic exp_t sample(input int s);
      exp_t a;
      a.st = state_w[s];      a.hit = hit_w[s];         a.miss = miss_w[s];
      a.way = way_w[s];       a.wl2 = wl2_w[s];         a.rl2 = rl2_w[s];
      a.ldr = ldr_w[s];       a.age_en = age_en_w[s];   a.cnt = count_w[s];
      a.tag_en = tag_en_w[s]; a.valid_en = valid_en_w[s]; a.dirty_en = dirty_en_w[s];
      a.dval = dval_w[s];     a.wl1 = wl1_w[s];         a.age_new = age_new_w[s];
      a.busy = busy_w[s];     a.tag_out = tag_out_w[s];
      return a;
   endfunction

   // way_sel is meaningless on a no-allocate store, ages only matter when
   // written, and the fill tag only when the tag array is written.
   task automatic cmp(input string name, input exp_t act, input exp_t e);
      exp_t m;
      logic [62:0] va, ve, vm;
      m = '1;
      if (e.st == 4'd3) m.way = '0;
      if (!e.age_en)    m.age_new = '0;
      if (e.st != 4'd6) m.tag_out = '0;
      va = act; ve = e; vm = m;
      chk(name, 64'(va & vm), 64'(ve & vm));
   endtask

   function automatic exp_t mk(input logic [3:0] s);
      exp_t e;
      e = '0;
      e.st = s;
      e.busy = (s != 4'd0);
      return e;
   endfunction

   // Recency list, MRU first: the accessed way moves to the front and each
   // way's new age is simply its position in the list.
   function automatic logic [7:0] lru(input int a, input int ag[4]);
      int order[$];
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
         for (int w = 0; w < 4; w++)
            if (ag[w] == k) order.push_back(w);
      for (int k = 0; k < order.size(); k++)
         if (order[k] == a) begin
            order.delete(k);
            break;
         end
      order.push_front(a);
      for (int k = 0; k < 4; k++) r[order[k]*2 +: 2] = 2'(k);
      return r;
   endfunction

   function automatic exp_t final_cycle(input bit opld, input int a, input int ag[4]);
      exp_t e;
      e = mk(opld ? 4'd1 : 4'd2);
      e.way = 2'(a);
      e.age_en = 1'b1;
      e.age_new = lru(a, ag);
      if (opld) e.ldr = 1'b1;
      else begin
         e.wl1 = 4'(1 << a);
         e.dirty_en = 4'(1 << a);
         e.dval = 1'b1;
      end
      return e;
   endfunction

   // Expands one accepted request into its expected cycle-by-cycle outputs.
   function automatic void model(input int wa, input bit opld, input logic [20:0] rt,
                                 input logic [20:0] tg[4], input logic [3:0] v,
                                 input logic [3:0] d, input int ag[4], input int dly);
      int hw = -1, vw = -1;
      exp_t e;
      q_exp.delete();
      for (int w = 0; w < 4; w++) if (hw < 0 && v[w] && tg[w] == rt) hw = w;
      for (int w = 0; w < 4; w++) if (vw < 0 && !v[w]) vw = w;
      for (int w = 0; w < 4; w++) if (vw < 0 && ag[w] == 3) vw = w;
      if (hw >= 0) begin
         e = final_cycle(opld, hw, ag);
         e.hit = 1'b1;
         q_exp.push_back(e);
         return;
      end
      if (!opld && wa == 0) begin
         for (int i = 0; i < 8; i++) begin
            e = mk(4'd3); e.wl2 = 1'b1; e.cnt = 4'(i);
            q_exp.push_back(e);
         end
      end else begin
         if (v[vw] && d[vw]) begin
            for (int i = 0; i < 8; i++) begin
               e = mk(4'd4); e.way = 2'(vw); e.wl2 = 1'b1; e.cnt = 4'(i);
               if (i == 7) e.dirty_en = 4'(1 << vw);
               q_exp.push_back(e);
            end
         end
         for (int j = 0; j <= dly; j++) begin
            e = mk(4'd5); e.way = 2'(vw); e.rl2 = 1'b1;
            q_exp.push_back(e);
         end
         e = mk(4'd6); e.way = 2'(vw);
         e.tag_en = 4'(1 << vw); e.valid_en = 4'(1 << vw);
         e.dirty_en = 4'(1 << vw); e.wl1 = 4'(1 << vw); e.tag_out = rt;
         q_exp.push_back(e);
         q_exp.push_back(final_cycle(opld, vw, ag));
      end
      q_exp[0].miss = 1'b1;
   endfunction

   task automatic run_txn(input int s, input int n);
      logic [20:0] tg[4];
      int   ag[4];
      logic [20:0] rt;
      int   dly, opsel, ai, j, tmp;
      bit   opld;
      exp_t e;
      for (int w = 0; w < 4; w++) begin
         tg[w] = 21'h100 + 21'($urandom_range(0, 3));
         ag[w] = w;
      end
      for (int i = 3; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = ag[i]; ag[i] = ag[j]; ag[j] = tmp;
      end
      rt    = 21'h100 + 21'($urandom_range(0, 4));
      dly   = $urandom_range(0, 3);
      opsel = $urandom_range(0, 3);
      opld  = (opsel == 0) || (opsel == 2);
      vl    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      dt    = 4'($urandom);
      chk($sformatf("r%0d_%0d_idle", s, n), 64'(state_w[s]), 64'd0);
      tags  = {tg[3], tg[2], tg[1], tg[0]};
      ages  = {2'(ag[3]), 2'(ag[2]), 2'(ag[1]), 2'(ag[0])};
      addr  = {rt, 11'($urandom)};
      ld_v[s] = opld;
      st_v[s] = (opsel != 0);
      ack = 1'b0;
      model(s, opld, rt, tg, vl, dt, ag, dly);
      tick();
      ai = 0;
      for (int k = 0; k < q_exp.size(); k++) begin
         e = q_exp[k];
         cmp($sformatf("r%0d_%0d_c%0d", s, n, k), sample(s), e);
         ld_v[s] = 1'($urandom_range(0, 1));
         st_v[s] = 1'($urandom_range(0, 1));
         if (e.st == 4'd5) begin
            ack = (ai == dly);
            ai++;
         end else begin
            ack = 1'($urandom_range(0, 1));
         end
         tick();
      end
      ld_v[s] = 1'b0;
      st_v[s] = 1'b0;
      ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ld_v = '0; st_v = '0; ack = 1'b0; addr = '0;
      tags = '0; vl = '0; dt = '0; ages = 8'h87;

      tv[0] = '{1'b1, 1'b0, 32'hFFFFFFFF, {Z, T, Z, Z}, 4'hF, 8'h87, 4'd1, 2'd2, 8'h87};
      tv[1] = '{1'b1, 1'b0, 32'hFFFFFFFF, {Z, Z, T, Z}, 4'hF, 8'h87, 4'd1, 2'd1, 8'h93};
      tv[2] = '{1'b1, 1'b1, 32'hFFFFFFFF, {T, Z, Z, Z}, 4'hF, 8'h87, 4'd1, 2'd3, 8'h1B};
      tv[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, {T, Z, Z, Z}, 4'hF, 8'h87, 4'd2, 2'd3, 8'h1B};
      tv[4] = '{1'b1, 1'b0, 32'hFFFFFFFF, {Z, Z, Z, T}, 4'hF, 8'h87, 4'd1, 2'd0, 8'hD8};
      tv[5] = '{1'b1, 1'b0, 32'hFFFFFFFF, {T, Z, T, Z}, 4'hF, 8'h87, 4'd1, 2'd1, 8'h93};
      tv[6] = '{1'b0, 1'b1, 32'hFFFFFFFF, {Z, T, Z, T}, 4'hB, 8'h87, 4'd2, 2'd0, 8'hD8};
      tv[7] = '{1'b1, 1'b0, {21'h0ABCDE, 11'h123}, {21'h0ABCDE, Z, Z, Z}, 4'hF, 8'hE4, 4'd1, 2'd3, 8'h39};

      tick(); tick();
      chk("reset_outs_dut", 64'(sample(0)), 64'd0);
      chk("reset_outs_dut_wa", 64'(sample(1)), 64'd0);
      rst = 1'b0;
      tick();

      // Hit-path vectors on the no-allocate instance.
      for (int i = 0; i < 8; i++) begin
         ld_v[0] = tv[i].ld; st_v[0] = tv[i].st; addr = tv[i].addr;
         tags = tv[i].tags; vl = tv[i].valid; ages = tv[i].ages; dt = 4'h0;
         tick();
         ld_v[0] = 1'b0; st_v[0] = 1'b0;
         chk($sformatf("vec%0d_hit", i),
             64'({state_w[0], hit_w[0], miss_w[0], way_w[0], age_en_w[0], age_new_w[0]}),
             64'({tv[i].exp_state, 1'b1, 1'b0, tv[i].exp_way, 1'b1, tv[i].exp_age}));
         tick();
         chk($sformatf("vec%0d_idle", i), 64'({state_w[0], busy_w[0]}), 64'd0);
      end

      // Cold load: no valid ways, fill way 0 after a delayed ack.
      vl = 4'h0; dt = 4'h0; tags = '0; ages = 8'h87; addr = 32'hFFFFFFFF;
      ld_v[0] = 1'b1;
      tick();
      ld_v[0] = 1'b0;
      chk("cold_miss", 64'({state_w[0], miss_w[0], way_w[0], rl2_w[0], wl2_w[0]}),
          64'({4'd5, 1'b1, 2'd0, 1'b1, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("cold_wait%0d", i), 64'({state_w[0], miss_w[0], rl2_w[0]}),
             64'({4'd5, 1'b0, 1'b1}));
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("cold_update", 64'({state_w[0], tag_en_w[0], valid_en_w[0], wl1_w[0], dval_w[0], tag_out_w[0]}),
          64'({4'd6, 4'b0001, 4'b0001, 4'b0001, 1'b0, 21'h1FFFFF}));
      tick();
      chk("cold_read", 64'({state_w[0], ldr_w[0], age_en_w[0], age_new_w[0]}),
          64'({4'd1, 1'b1, 1'b1, 8'hD8}));
      tick();
      chk("cold_idle", 64'(state_w[0]), 64'd0);

      // Reset in the middle of a dirty write-back burst.
      vl = 4'hF; dt = 4'hF; tags = '0; ages = 8'h87; addr = 32'hFFFFFFFF;
      ld_v[0] = 1'b1;
      tick();
      ld_v[0] = 1'b0;
      chk("wb_entry", 64'({state_w[0], count_w[0], wl2_w[0], miss_w[0], way_w[0]}),
          64'({4'd4, 4'd0, 1'b1, 1'b1, 2'd0}));
      repeat (4) tick();
      chk("wb_count4", 64'({state_w[0], count_w[0], wl2_w[0]}), 64'({4'd4, 4'd4, 1'b1}));
      rst = 1'b1;
      #1;
      chk("wb_async_reset", 64'({state_w[0], count_w[0], wl2_w[0], busy_w[0], dirty_en_w[0]}), 64'd0);
      rst = 1'b0;
      tags = {Z, T, Z, Z};
      ld_v[0] = 1'b1;
      tick();
      ld_v[0] = 1'b0;
      chk("post_reset_hit", 64'({state_w[0], hit_w[0], way_w[0], ldr_w[0]}),
          64'({4'd1, 1'b1, 2'd2, 1'b1}));
      tick();

      // Random transactions on each write-allocate setting.
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < 40; n++)
            run_txn(s, n);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_controller_nway.md
Name: cache_controller_nway

Overview:
Parametrised N-way set-associative L1D cache controller FSM, the successor to the fixed 2-way controller. It covers the same L1/L2 path, generalised to WAYS ways with true-LRU age tracking. It adds an optional write-allocate mode, configurable L2 burst and write lengths, and an explicit busy indication. Tag, valid, dirty and age arrays live outside the block; this block compares tags, chooses the victim, sequences write-back and allocation with L2, and issues array write enables.

Parameters:
ADDR_W, 32, address width
TAG_W, 21, tag width; tag = addr[ADDR_W-1 -: TAG_W]
WAYS, 4, associativity, power of 2, range 2..8; AGE_W = clog2(WAYS)
BURST, 8, cycles of write_l2 for a dirty-line write-back
L2_WR_CYC, 8, cycles of write_l2 for a store miss with no allocate
WRITE_ALLOCATE, 0, 0 = store miss writes through to L2; 1 = store miss allocates, then writes L1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ld  in  1  load request, sampled in IDLE
st  in  1  store request, sampled in IDLE
addr  in  ADDR_W  request address
tag_loaded  in  WAYS*TAG_W  per-way tags for the indexed set; way w at [w*TAG_W +: TAG_W]
valid  in  WAYS  per-way valid bits
dirty  in  WAYS  per-way dirty bits
age  in  WAYS*AGE_W  per-way LRU age; 0 = MRU
l2_ack  in  1  L2 fill-data-ready acknowledge
hit  out  1  one-cycle pulse: request hit
miss  out  1  one-cycle pulse: request missed
way_sel  out  AGE_W  hit way or victim way of the current operation
tag_out  out  TAG_W  latched request tag, written to tag array on fill
tag_en  out  WAYS  tag write enable, one-hot
valid_en  out  WAYS  valid write enable (write value 1), one-hot
dirty_en  out  WAYS  dirty write enable, one-hot
dirty_val  out  1  value written under dirty_en
load_ready  out  1  load data valid
write_l1  out  WAYS  L1 data write strobe, one-hot
read_l2  out  1  L2 line-read request
write_l2  out  1  L2 write strobe
age_new  out  WAYS*AGE_W  updated LRU ages
age_en  out  1  age array write enable
state  out  4  current state
count  out  4  burst/write cycle counter
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous and at any time, including mid-burst: state = IDLE, count = 0, latched addr/op/way = 0, and every output = 0.
- State encoding: IDLE = 0, READ_L1 = 1, WRITE_L1 = 2, WRITE_L2 = 3, WRITE_BACK = 4, ALLOCATE = 5, UPDATE_L1 = 6. Codes 7..15 return to IDLE on the next edge.
- IDLE:
  - If ld or st is high, the request is accepted. If both are high, ld wins.
  - Request tag, op and addr are latched on that edge.
  - Hit means some way w has valid[w] and tag_loaded[w] equals the request tag. If several ways match, the lowest index wins.
  - Victim is the lowest-index invalid way; otherwise the way with age == WAYS-1; ties go to the lowest index.
- Transitions out of IDLE on the accept edge:
  - ld hit -> READ_L1.
  - st hit -> WRITE_L1.
  - ld miss, or st miss with WRITE_ALLOCATE = 1: if the victim is valid and dirty -> WRITE_BACK, else -> ALLOCATE.
  - st miss with WRITE_ALLOCATE = 0 -> WRITE_L2.
- hit/miss pulse during the first cycle of the state entered; they are 0 otherwise.
- READ_L1, 1 cycle: load_ready = 1, age_en = 1 -> IDLE.
- WRITE_L1, 1 cycle: write_l1[way] = 1, dirty_en[way] = 1, dirty_val = 1, age_en = 1 -> IDLE.
- WRITE_L2: write_l2 = 1 for exactly L2_WR_CYC cycles; count runs 0..L2_WR_CYC-1 -> IDLE. LRU and arrays are unchanged.
- WRITE_BACK: write_l2 = 1 for exactly BURST cycles; count runs 0..BURST-1. On the last cycle: dirty_en[victim] = 1, dirty_val = 0 -> ALLOCATE.
- ALLOCATE: read_l2 = 1 each cycle until l2_ack is sampled high, with no timeout. The ack edge -> UPDATE_L1. l2_ack is ignored in all other states.
- UPDATE_L1, 1 cycle:
  - tag_en, valid_en, dirty_en and write_l1 are all asserted on the victim; dirty_val = 0; tag_out = latched tag.
  - Next state: a load -> READ_L1; an allocating store -> WRITE_L1.
  - Age is not updated here; it is updated in the following READ_L1/WRITE_L1.
- LRU update, when age_en = 1 for accessed way a:
  - age_new[a] = 0.
  - Every way with age < age[a] gets +1.
  - All other ways are unchanged.
  - The result is always a permutation of 0..WAYS-1.
- count is 0 outside WRITE_L2/WRITE_BACK and resets to 0 on each entry.
- ld/st while busy are ignored, not queued.
- Inputs tag_loaded, valid, dirty and age are used in IDLE on the accept edge and for the age update. The environment holds the set index stable from accept until return to IDLE.

Test Plan:
- WAYS = 4, cold ld addr = 0xFFFFFFFF, all valid = 0 -> miss pulse; WRITE_BACK is skipped; way_sel = 0; read_l2 high until l2_ack; UPDATE_L1 with tag_en = 0001, tag_out = 0x1FFFFF; then READ_L1 with load_ready; age_new[0] = 0.
- All ways valid, tag_loaded[2] = 0x1FFFFF, ages {3,1,0,2}, ld 0xFFFFFFFF -> hit, READ_L1, age_new = {3,2,0,2}? No: ways with age < 0 do not exist, so ages stay {3,1,0,2}; then repeat with tag match on way 1 -> age_new = {3,0,1,2}.
- Miss with the age-3 victim dirty -> write_l2 for exactly 8 cycles, count 0..7, dirty_en pulse with dirty_val = 0; then ALLOCATE, UPDATE_L1 and READ_L1.
- st miss, WRITE_ALLOCATE = 0 -> write_l2 for 8 cycles, no L1 enables, no age_en; WRITE_ALLOCATE = 1 -> ALLOCATE, UPDATE_L1, then WRITE_L1 with dirty_val = 1.
- ld and st together on a hit -> load path taken (READ_L1); ld pulsed during ALLOCATE -> ignored.
- reset asserted at WRITE_BACK count = 4 -> immediately state = 0, write_l2 = 0, count = 0; a following ld is handled normally.
